// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: default widths, FSM states and requester ids.
package mem_arb_pkg;

    localparam int unsigned DefAddrW = 16;
    localparam int unsigned DefDataW = 8;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAccess  = 2'd1,
        StCapture = 2'd2
    } state_e;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Two-way combinational picker: returns the id of the requester that wins this cycle.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (alternate on ties; otherwise data wins ties).
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic f_req_i,
    input  logic d_req_i,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic last_i,
`endif
    output logic winner_o
);

    // Winner is only meaningful when at least one request is present.
    always_comb begin
        winner_o = REQ_DATA;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (f_req_i && d_req_i) begin
            // Ids are one bit wide, so the other requester is the inverse of last.
            winner_o = ~last_i;
        end else if (f_req_i) begin
            winner_o = REQ_FETCH;
        end
`else
        if (f_req_i && !d_req_i) begin
            winner_o = REQ_FETCH;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a tape data port onto one synchronous memory.
// Write: IDLE -> ACCESS -> IDLE. Read: IDLE -> ACCESS -> CAPTURE -> IDLE.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin ties; default fixed data priority).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              f_req_i,
    input  logic [ADDR_W-1:0] f_addr_i,
    output logic              f_gnt_o,
    output logic [DATA_W-1:0] f_rdata_o,
    output logic              f_rvalid_o,

    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_rvalid_o,

    output logic              m_active_o,
    output logic              m_read_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [DATA_W-1:0] m_wdata_o,
    input  logic [DATA_W-1:0] m_rdata_i,

    output logic              busy_o
);

    state_e              state_q;
    logic                winner_q;
    logic                f_gnt_q;
    logic                d_gnt_q;
    logic                f_rvalid_q;
    logic                d_rvalid_q;
    logic [DATA_W-1:0]   f_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;
    logic                m_active_q;
    logic                m_read_q;
    logic [ADDR_W-1:0]   m_addr_q;
    logic [DATA_W-1:0]   m_wdata_q;
    logic                pick;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                last_q;
`endif

    arb_pick u_arb_pick (
        .f_req_i  (f_req_i),
        .d_req_i  (d_req_i),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_i   (last_q),
`endif
        .winner_o (pick)
    );

    // FSM with registered memory-side and requester-side outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            winner_q   <= REQ_FETCH;
            f_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            f_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            f_rdata_q  <= '0;
            d_rdata_q  <= '0;
            m_active_q <= 1'b0;
            m_read_q   <= 1'b1;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q     <= REQ_FETCH;
`endif
        end else begin
            // Pulses default low; each is raised for exactly one cycle below.
            f_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            f_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            m_active_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (f_req_i || d_req_i) begin
                        state_q    <= StAccess;
                        winner_q   <= pick;
                        m_active_q <= 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_q     <= pick;
`endif
                        if (pick == REQ_DATA) begin
                            d_gnt_q  <= 1'b1;
                            m_addr_q <= d_addr_i;
                            m_read_q <= ~d_we_i;
                            // Write data is left untouched on reads.
                            if (d_we_i) begin
                                m_wdata_q <= d_wdata_i;
                            end
                        end else begin
                            f_gnt_q  <= 1'b1;
                            m_addr_q <= f_addr_i;
                            m_read_q <= 1'b1;
                        end
                    end
                end
                StAccess: begin
                    state_q <= m_read_q ? StCapture : StIdle;
                end
                StCapture: begin
                    state_q <= StIdle;
                    if (winner_q == REQ_DATA) begin
                        d_rdata_q  <= m_rdata_i;
                        d_rvalid_q <= 1'b1;
                    end else begin
                        f_rdata_q  <= m_rdata_i;
                        f_rvalid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign f_gnt_o    = f_gnt_q;
    assign d_gnt_o    = d_gnt_q;
    assign f_rvalid_o = f_rvalid_q;
    assign d_rvalid_o = d_rvalid_q;
    assign f_rdata_o  = f_rdata_q;
    assign d_rdata_o  = d_rdata_q;
    assign m_active_o = m_active_q;
    assign m_read_o   = m_read_q;
    assign m_addr_o   = m_addr_q;
    assign m_wdata_o  = m_wdata_q;
    assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural synchronous memory.
// Honours MEM_ARB_ROUND_ROBIN_EN when choosing the expected tie-break order.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req, f_gnt, f_rvalid;
    logic [15:0] f_addr;
    logic [7:0]  f_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [15:0] d_addr;
    logic [7:0]  d_wdata, d_rdata;
    logic        m_active, m_read, busy;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata;
    logic [7:0]  m_rdata;

    int n_cmp = 0;
    int n_err = 0;
    int onehot_viol = 0;

    // Behavioural memory plus a bench-side preload port.
    logic [7:0]  mem [0:65535];
    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (m_active) begin
            if (m_read) m_rdata <= mem[m_addr];
            else        mem[m_addr] <= m_wdata;
        end
    end

    always @(negedge clk) begin
        if (rst_n && (int'(f_gnt) + int'(d_gnt) + int'(f_rvalid) + int'(d_rvalid)) > 1)
            onehot_viol++;
    end

    mem_arbiter dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .f_req_i    (f_req),
        .f_addr_i   (f_addr),
        .f_gnt_o    (f_gnt),
        .f_rdata_o  (f_rdata),
        .f_rvalid_o (f_rvalid),
        .d_req_i    (d_req),
        .d_we_i     (d_we),
        .d_addr_i   (d_addr),
        .d_wdata_i  (d_wdata),
        .d_gnt_o    (d_gnt),
        .d_rdata_o  (d_rdata),
        .d_rvalid_o (d_rvalid),
        .m_active_o (m_active),
        .m_read_o   (m_read),
        .m_addr_o   (m_addr),
        .m_wdata_o  (m_wdata),
        .m_rdata_i  (m_rdata),
        .busy_o     (busy)
    );

    localparam logic [47:0] RST_VEC = {1'b0, 1'b1, 16'h0000, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0};

    function automatic logic [47:0] out_vec();
        return {m_active, m_read, m_addr, m_wdata, f_gnt, d_gnt, f_rvalid, d_rvalid,
                f_rdata, d_rdata, busy};
    endfunction

    task automatic preload(input logic [15:0] a, input logic [7:0] v);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = v;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        f_addr = '0; d_addr = '0; d_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (out_vec() !== RST_VEC) begin
            $display("FAIL reset_outputs: got %h want %h", out_vec(), RST_VEC);
            n_err++;
        end
    endtask

    task automatic test_fetch_read();
        @(negedge clk);
        f_req = 1'b1; f_addr = 16'h0012;
        @(negedge clk);
        n_cmp++;
        if ({f_gnt, d_gnt, m_active, m_read, m_addr, busy} !== {4'b1011, 16'h0012, 1'b1}) begin
            $display("FAIL fetch_grant: got %b/%b/%b/%b/%h/%b want 1/0/1/1/0012/1",
                     f_gnt, d_gnt, m_active, m_read, m_addr, busy);
            n_err++;
        end
        f_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({f_gnt, m_active, f_rvalid, busy} !== 4'b0001) begin
            $display("FAIL fetch_capture: got gnt=%b act=%b rv=%b busy=%b want 0 0 0 1",
                     f_gnt, m_active, f_rvalid, busy);
            n_err++;
        end
        @(negedge clk);
        n_cmp++;
        if ({f_rvalid, d_rvalid, f_rdata, busy} !== {2'b10, 8'hAB, 1'b0}) begin
            $display("FAIL fetch_rvalid: got rv=%b drv=%b data=%h busy=%b want 1 0 ab 0",
                     f_rvalid, d_rvalid, f_rdata, busy);
            n_err++;
        end
        @(negedge clk);
        n_cmp++;
        if (f_rvalid !== 1'b0) begin
            $display("FAIL fetch_rvalid_pulse: got %b want 0", f_rvalid);
            n_err++;
        end
    endtask

    task automatic test_data_write_read();
        int f_rv_cnt = 0;
        int d_rv_cnt = 0;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0013; d_wdata = 8'h10;
        @(negedge clk);
        n_cmp++;
        if ({d_gnt, f_gnt, m_active, m_read, m_addr, m_wdata} !== {4'b1010, 16'h0013, 8'h10}) begin
            $display("FAIL data_write_grant: got %b/%b/%b/%b/%h/%h want 1/0/1/0/0013/10",
                     d_gnt, f_gnt, m_active, m_read, m_addr, m_wdata);
            n_err++;
        end
        d_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, m_active, mem[16'h0013]} !== {2'b00, 8'h10}) begin
            $display("FAIL data_write_commit: got busy=%b act=%b mem=%h want 0 0 10",
                     busy, m_active, mem[16'h0013]);
            n_err++;
        end
        d_req = 1'b1; d_we = 1'b0; d_wdata = 8'hFF;
        @(negedge clk);
        n_cmp++;
        if ({d_gnt, m_read, m_addr, m_wdata} !== {2'b11, 16'h0013, 8'h10}) begin
            $display("FAIL data_read_grant: got gnt=%b rd=%b addr=%h wd=%h want 1 1 0013 10",
                     d_gnt, m_read, m_addr, m_wdata);
            n_err++;
        end
        d_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (d_rvalid) d_rv_cnt++;
            if (f_rvalid) f_rv_cnt++;
            if (i == 1) begin
                n_cmp++;
                if ({d_rvalid, d_rdata, f_rdata} !== {1'b1, 8'h10, 8'hAB}) begin
                    $display("FAIL data_read_data: got rv=%b d=%h f=%h want 1 10 ab",
                             d_rvalid, d_rdata, f_rdata);
                    n_err++;
                end
            end
        end
        n_cmp++;
        if (d_rv_cnt != 1 || f_rv_cnt != 0) begin
            $display("FAIL data_read_counts: got d_rvalid=%0d f_rvalid=%0d want 1 0",
                     d_rv_cnt, f_rv_cnt);
            n_err++;
        end
    endtask

    task automatic test_priority();
        logic [3:0] seq = '0;
        logic [3:0] exp_seq;
        int ng = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_seq = 4'b0101;
`else
        exp_seq = 4'b1111;
`endif
        apply_reset();
        @(negedge clk);
        f_req = 1'b1; f_addr = 16'h0012;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 8'h77;
        for (int i = 0; i < 30 && ng < 4; i++) begin
            @(negedge clk);
            if (f_gnt || d_gnt) begin
                seq[ng] = d_gnt;
                ng++;
            end
        end
        f_req = 1'b0; d_req = 1'b0;
        n_cmp++;
        if (ng != 4 || seq !== exp_seq) begin
            $display("FAIL priority_order: got %0d grants seq=%b want 4 seq=%b", ng, seq, exp_seq);
            n_err++;
        end
        for (int i = 0; i < 5 && busy; i++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        // Reset with a read in CAPTURE: no rvalid, outputs back to reset values.
        @(negedge clk);
        f_req = 1'b1; f_addr = 16'h0012;
        @(negedge clk);
        f_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || m_active !== 1'b0) begin
            $display("FAIL reset_mid_setup: got busy=%b act=%b want 1 0", busy, m_active);
            n_err++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if (out_vec() !== RST_VEC) begin
            $display("FAIL reset_mid_read: got %h want %h", out_vec(), RST_VEC);
            n_err++;
        end
        @(negedge clk);
        n_cmp++;
        if (f_rvalid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL reset_mid_after: got rv=%b busy=%b want 0 0", f_rvalid, busy);
            n_err++;
        end
        // Reset while a write is in ACCESS: the write still lands.
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 8'h5A;
        @(negedge clk);
        d_req = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if (mem[16'h0020] !== 8'h5A || busy !== 1'b0) begin
            $display("FAIL reset_mid_write: got mem=%h busy=%b want 5a 0", mem[16'h0020], busy);
            n_err++;
        end
    endtask

    task automatic test_back_to_back();
        int gnts = 0;
        int act_bad = 0;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0000; d_wdata = 8'hC0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m_active !== ((i % 2) == 0)) act_bad++;
            if (d_gnt) begin
                gnts++;
                if (gnts < 4) begin
                    d_addr = 16'(gnts); d_wdata = 8'hC0 + 8'(gnts);
                end else begin
                    d_req = 1'b0;
                end
            end
        end
        n_cmp++;
        if (act_bad != 0 || gnts != 4) begin
            $display("FAIL b2b_pattern: got act_bad=%0d gnts=%0d want 0 4", act_bad, gnts);
            n_err++;
        end
        @(negedge clk);
        n_cmp++;
        if ({mem[0], mem[1], mem[2], mem[3]} !== 32'hC0C1C2C3 || f_gnt !== 1'b0) begin
            $display("FAIL b2b_mem: got %h%h%h%h want c0c1c2c3",
                     mem[0], mem[1], mem[2], mem[3]);
            n_err++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        f_addr = '0; d_addr = '0; d_wdata = '0;
        preload(16'h0012, 8'hAB);
        test_reset();
        test_fetch_read();
        test_data_write_read();
        test_priority();
        test_reset_mid();
        test_back_to_back();
        n_cmp++;
        if (onehot_viol != 0) begin
            $display("FAIL onehot_pulses: got %0d violations want 0", onehot_viol);
            n_err++;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
